// File: rtl/fetch_sequencer.sv
// Instruction fetch front end: owns the PC, captures ROM data into a one-entry slot for decode.
// Optional `PC_WRAP_TRAP_EN turns a fetch from address 8'hFF into a trapped halt instead of a wrap.
module fetch_sequencer #(
   parameter logic [7:0] RESET_PC    = 8'h00,
   parameter logic [7:0] HALT_OPCODE = 8'hFF
) (
   input  logic       clk,
   input  logic       reset,
   output logic [7:0] pc_out,
   input  logic [7:0] instr_in,
   output logic [7:0] instr_out,
   output logic [7:0] instr_pc,
   output logic       instr_valid,
   input  logic       decode_ready,
   input  logic       stall,
   input  logic       branch_taken,
   input  logic [7:0] branch_target,
   output logic       halted
`ifdef PC_WRAP_TRAP_EN
   ,
   output logic       wrap_trap
`endif
);

   typedef enum logic [1:0] {
      START = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t state;
   logic   slot_free;
   logic   capture;
   logic   is_halt_op;
   logic   trap_hit;

   assign slot_free  = !instr_valid || decode_ready;
   assign capture    = (state == RUN) && !branch_taken && !stall && slot_free;
   assign is_halt_op = (instr_in == HALT_OPCODE);

`ifdef PC_WRAP_TRAP_EN
   assign trap_hit = (pc_out == 8'hFF);
`else
   assign trap_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= START;
         pc_out      <= RESET_PC;
         instr_out   <= 8'h00;
         instr_pc    <= 8'h00;
         instr_valid <= 1'b0;
         halted      <= 1'b0;
      end else begin
         case (state)
            START: begin
               if (branch_taken) begin
                  pc_out      <= branch_target;
                  instr_valid <= 1'b0;
               end
               state <= RUN;
            end

            RUN: begin
               if (branch_taken) begin
                  pc_out      <= branch_target;
                  instr_valid <= 1'b0;
               end else if (stall) begin
                  // a pending handshake still retires while fetch is frozen
                  if (decode_ready) instr_valid <= 1'b0;
               end else if (capture) begin
                  instr_out   <= instr_in;
                  instr_pc    <= pc_out;
                  instr_valid <= 1'b1;
                  if (is_halt_op || trap_hit) state <= DRAIN;
                  else                        pc_out <= pc_out + 8'd1;
               end
            end

            DRAIN: begin
               if (branch_taken) begin
                  pc_out      <= branch_target;
                  instr_valid <= 1'b0;
                  state       <= RUN;
               end else if (decode_ready) begin
                  instr_valid <= 1'b0;
                  halted      <= 1'b1;
                  state       <= HALT;
               end
            end

            HALT: begin
               halted      <= 1'b1;
               instr_valid <= 1'b0;
            end

            default: state <= START;
         endcase
      end
   end

`ifdef PC_WRAP_TRAP_EN
   // halt opcodes take precedence: a halt at 8'hFF is an ordinary halt, not a trap
   always_ff @(posedge clk) begin
      if (reset)                                 wrap_trap <= 1'b0;
      else if (state == DRAIN && branch_taken)   wrap_trap <= 1'b0;
      else if (capture && !is_halt_op && trap_hit) wrap_trap <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed literal scenarios plus randomized traffic checked
// every cycle against a transaction-level model of the fetch slot.
module tb_fetch_sequencer;

   localparam logic [7:0] RPC  = 8'h00;
   localparam logic [7:0] HALT = 8'hFF;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       decode_ready = 1'b0;
   logic       stall = 1'b0;
   logic       branch_taken = 1'b0;
   logic [7:0] branch_target = 8'h00;
   logic [7:0] pc_out, instr_in, instr_out, instr_pc;
   logic       instr_valid, halted;
`ifdef PC_WRAP_TRAP_EN
   logic       wrap_trap;
`endif

   logic [7:0] rom [256];
   assign instr_in = rom[pc_out];

   always #5 clk = ~clk;

   fetch_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .pc_out        (pc_out),
      .instr_in      (instr_in),
      .instr_out     (instr_out),
      .instr_pc      (instr_pc),
      .instr_valid   (instr_valid),
      .decode_ready  (decode_ready),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .halted        (halted)
`ifdef PC_WRAP_TRAP_EN
      ,
      .wrap_trap     (wrap_trap)
`endif
   );

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the slot, the next address to fetch, and a few mode flags.
   logic [7:0] m_pc, m_instr, m_ipc;
   bit         m_valid, m_halted, m_trap, m_started, m_pending;

   always @(posedge clk) begin
      if (reset) begin
         m_pc <= RPC; m_instr <= 8'h00; m_ipc <= 8'h00; m_valid <= 1'b0;
         m_halted <= 1'b0; m_trap <= 1'b0; m_started <= 1'b0; m_pending <= 1'b0;
      end else if (m_halted) begin
         m_valid <= 1'b0;
      end else if (branch_taken) begin
         m_pc <= branch_target; m_valid <= 1'b0; m_started <= 1'b1;
         m_pending <= 1'b0; m_trap <= 1'b0;
      end else if (!m_started) begin
         m_started <= 1'b1;
      end else if (m_pending) begin
         if (decode_ready) begin
            m_valid <= 1'b0; m_halted <= 1'b1; m_pending <= 1'b0;
         end
      end else if (stall) begin
         if (decode_ready) m_valid <= 1'b0;
      end else if (!m_valid || decode_ready) begin
         m_instr <= rom[m_pc]; m_ipc <= m_pc; m_valid <= 1'b1;
         if (rom[m_pc] == HALT) m_pending <= 1'b1;
`ifdef PC_WRAP_TRAP_EN
         else if (m_pc == 8'hFF) begin
            m_pending <= 1'b1; m_trap <= 1'b1;
         end
`endif
         else m_pc <= m_pc + 8'd1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model pc_out", pc_out, m_pc);
         check("model instr_valid", {7'd0, instr_valid}, {7'd0, m_valid});
         check("model halted", {7'd0, halted}, {7'd0, m_halted});
         check("model instr_out", instr_out, m_instr);
         check("model instr_pc", instr_pc, m_ipc);
`ifdef PC_WRAP_TRAP_EN
         check("model wrap_trap", {7'd0, wrap_trap}, {7'd0, m_trap});
`endif
      end
   end

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic expect_slot(input string tag, input logic v, input logic [7:0] ins,
                              input logic [7:0] ipc, input logic [7:0] pc, input logic h);
      check({tag, " valid"}, {7'd0, instr_valid}, {7'd0, v});
      check({tag, " instr"}, instr_out, ins);
      check({tag, " ipc"}, instr_pc, ipc);
      check({tag, " pc"}, pc_out, pc);
      check({tag, " halted"}, {7'd0, halted}, {7'd0, h});
   endtask

   task automatic fill_rom();
      for (int i = 0; i < 256; i++) begin
         rom[i] = ($urandom_range(0, 39) == 0) ? HALT : 8'($urandom_range(0, 254));
      end
   endtask

   task automatic restart();
      reset = 1'b1;
      cyc();
      reset = 1'b0;
   endtask

   initial begin
      fill_rom();
      rom[8'h00] = 8'h39; rom[8'h01] = 8'h12; rom[8'h02] = HALT;
      rom[8'h40] = 8'h55; rom[8'h60] = 8'h66; rom[8'h10] = 8'h21;
      decode_ready = 1'b1;
      cyc();
      chk_en = 1'b1;

      // program run to halt
      expect_slot("reset", 1'b0, 8'h00, 8'h00, RPC, 1'b0);
      reset = 1'b0;
      cyc(); expect_slot("start", 1'b0, 8'h00, 8'h00, 8'h00, 1'b0);
      cyc(); expect_slot("run0", 1'b1, 8'h39, 8'h00, 8'h01, 1'b0);
      cyc(); expect_slot("run1", 1'b1, 8'h12, 8'h01, 8'h02, 1'b0);
      cyc(); expect_slot("run2", 1'b1, 8'hFF, 8'h02, 8'h02, 1'b0);
      cyc(); expect_slot("halt", 1'b0, 8'hFF, 8'h02, 8'h02, 1'b1);
      branch_taken = 1'b1; branch_target = 8'h33;
      cyc(); branch_taken = 1'b0;
      expect_slot("halt_br", 1'b0, 8'hFF, 8'h02, 8'h02, 1'b1);

      // backpressure
      restart();
      cyc(); cyc();
      expect_slot("bp_first", 1'b1, 8'h39, 8'h00, 8'h01, 1'b0);
      decode_ready = 1'b0;
      repeat (3) begin
         cyc(); expect_slot("bp_hold", 1'b1, 8'h39, 8'h00, 8'h01, 1'b0);
      end
      decode_ready = 1'b1;
      cyc(); expect_slot("bp_resume", 1'b1, 8'h12, 8'h01, 8'h02, 1'b0);

      // branch flushes a held slot
      decode_ready = 1'b0; branch_taken = 1'b1; branch_target = 8'h40;
      cyc(); branch_taken = 1'b0; decode_ready = 1'b1;
      expect_slot("br_flush", 1'b0, 8'h12, 8'h01, 8'h40, 1'b0);
      cyc(); expect_slot("br_tgt", 1'b1, 8'h55, 8'h40, 8'h41, 1'b0);

      // stall, with a redirect during the stall
      stall = 1'b1;
      cyc(); expect_slot("stall1", 1'b0, 8'h55, 8'h40, 8'h41, 1'b0);
      cyc(); expect_slot("stall2", 1'b0, 8'h55, 8'h40, 8'h41, 1'b0);
      branch_taken = 1'b1; branch_target = 8'h60;
      cyc(); branch_taken = 1'b0; stall = 1'b0;
      expect_slot("stall_br", 1'b0, 8'h55, 8'h40, 8'h60, 1'b0);
      cyc(); expect_slot("stall_go", 1'b1, 8'h66, 8'h60, 8'h61, 1'b0);

      // branch out of a pending halt
      restart();
      cyc(); cyc(); cyc(); cyc();
      expect_slot("dr_cap", 1'b1, 8'hFF, 8'h02, 8'h02, 1'b0);
      decode_ready = 1'b0;
      cyc(); expect_slot("dr_wait", 1'b1, 8'hFF, 8'h02, 8'h02, 1'b0);
      branch_taken = 1'b1; branch_target = 8'h10;
      cyc(); branch_taken = 1'b0; decode_ready = 1'b1;
      expect_slot("dr_br", 1'b0, 8'hFF, 8'h02, 8'h10, 1'b0);
      cyc(); expect_slot("dr_go", 1'b1, 8'h21, 8'h10, 8'h11, 1'b0);

      // PC wrap at the top of the ROM, then reset mid-run
      rom[8'hFE] = 8'h01; rom[8'hFF] = 8'h02; rom[8'h00] = 8'h03;
      restart();
      branch_taken = 1'b1; branch_target = 8'hFE;
      cyc(); branch_taken = 1'b0;
      expect_slot("wr_br", 1'b0, 8'h00, 8'h00, 8'hFE, 1'b0);
      cyc(); expect_slot("wr_fe", 1'b1, 8'h01, 8'hFE, 8'hFF, 1'b0);
`ifdef PC_WRAP_TRAP_EN
      cyc(); expect_slot("wr_ff", 1'b1, 8'h02, 8'hFF, 8'hFF, 1'b0);
      check("wr_trap_set", {7'd0, wrap_trap}, 8'h01);
      cyc(); expect_slot("wr_halt", 1'b0, 8'h02, 8'hFF, 8'hFF, 1'b1);
      check("wr_trap_hold", {7'd0, wrap_trap}, 8'h01);
`else
      cyc(); expect_slot("wr_ff", 1'b1, 8'h02, 8'hFF, 8'h00, 1'b0);
      cyc(); expect_slot("wr_00", 1'b1, 8'h03, 8'h00, 8'h01, 1'b0);
`endif
      reset = 1'b1;
      cyc(); expect_slot("mid_reset", 1'b0, 8'h00, 8'h00, RPC, 1'b0);

      // randomized traffic
      fill_rom();
      for (int i = 0; i < 4000; i++) begin
         reset         = ($urandom_range(0, 79) == 0);
         branch_taken  = ($urandom_range(0, 9) == 0);
         branch_target = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(252, 255))
                                                     : 8'($urandom_range(0, 255));
         stall         = ($urandom_range(0, 5) == 0);
         decode_ready  = ($urandom_range(0, 2) != 0);
         cyc();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
